mul_result_normalizer: RTL and testbench

- Downstream stage of the shift-add sign-magnitude multiplier in the FFT datapath.
- Detects each newly completed multiplication from the multiplier's `ready`, `sign` and magnitude outputs.
- Rescales the double-width fixed-point magnitude back to WIDTH-bit sign-magnitude Q format, with rounding and saturation.
- Delivers results through a 2-entry buffered valid/ready interface to the butterfly adder.

---
 rtl/mul_result_normalizer.sv | 101 ++++++++++
 tb/tb_mul_result_normalizer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_result_normalizer.sv
// Rescales the multiplier's double-width magnitude to WIDTH-bit sign-magnitude (round half-up, saturate)
// and queues results in a 2-entry valid/ready buffer; a push into a full buffer is dropped and flagged.
module mul_result_normalizer #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               mul_ready,
  input  logic               mul_sign,
  input  logic [2*WIDTH-3:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sat,
  output logic               overflow
);
  localparam int PW = 2*WIDTH-2;
  localparam int MW = PW-FRAC+1;
  localparam logic [MW-1:0] MAX_MAG = MW'(2**(WIDTH-1)-1);

  logic             r_ready_d;
  logic [WIDTH:0]   r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sat;
  logic             r_overflow;

  logic             w_capture;
  logic [MW-1:0]    w_m;
  logic             w_sat;
  logic [WIDTH-2:0] w_mag;
  logic             w_sign;
  logic [WIDTH:0]   w_entry;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_rd_next;
  logic [1:0]       w_cnt_next;
  logic [WIDTH:0]   w_head_next;

  assign w_capture = mul_ready & ~r_ready_d;

  // Full-width sum so a carry out of the kept bits still reaches the saturation compare.
  assign w_m     = {1'b0, mul_product[PW-1:FRAC]} + MW'(mul_product[FRAC-1]);
  assign w_sat   = (w_m > MAX_MAG);
  assign w_mag   = w_sat ? {(WIDTH-1){1'b1}} : w_m[WIDTH-2:0];
  assign w_sign  = mul_sign & (w_mag != '0);
  assign w_entry = {w_sign, w_mag, w_sat};

  assign w_pop  = (r_count != 2'd0) & out_ready;
  assign w_push = w_capture & ((r_count != 2'd2) | w_pop);
  assign w_drop = w_capture & (r_count == 2'd2) & ~w_pop;

  assign w_rd_next  = r_rd_ptr ^ w_pop;
  assign w_cnt_next = r_count + 2'(w_push) - 2'(w_pop);

  // The entry being written this edge bypasses storage when it becomes the head.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_entry;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_ready_d  <= 1'b1;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_overflow <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_ready_d <= mul_ready;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_cnt_next != 2'd0) begin
        r_out_data <= w_head_next[WIDTH:1];
        r_out_sat  <= w_head_next[0];
      end
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_mul_result_normalizer.sv
// Bench for mul_result_normalizer: queue-based reference model checked every cycle,
// plus directed literal checks on rounding, saturation, overflow and reset behaviour.
module tb_mul_result_normalizer;
  localparam int WIDTH = 8;
  localparam int FRAC  = 6;

  logic         clkin = 1'b0;
  logic         rst = 1'b1;
  logic         mul_ready = 1'b0;
  logic         mul_sign = 1'b0;
  logic [13:0]  mul_product = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_sat;
  logic         overflow;

  int n_checks = 0;
  int n_fail = 0;
  bit model_en = 1'b0;

  // Reference model state: queue of {data, sat}
  logic [8:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b1;
  logic [8:0] m_last = '0;

  mul_result_normalizer #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clkin(clkin), .rst(rst), .mul_ready(mul_ready), .mul_sign(mul_sign),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .overflow(overflow)
  );

  always #5 clkin = ~clkin;

  function automatic logic [8:0] expect_entry(input int p, input bit s);
    int mag;
    bit sat;
    mag = (p / 64) + ((p / 32) % 2);
    sat = (mag > 127);
    if (sat) mag = 127;
    if (mag == 0) s = 1'b0;
    return {s, 7'(mag), sat};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT samples its inputs
  always @(posedge clkin) begin
    bit cap;
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b1;
      m_last = '0;
    end else begin
      cap = mul_ready && !m_prev;
      m_prev = mul_ready;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (cap) begin
        if (q.size() < 2) q.push_back(expect_entry(int'(mul_product), mul_sign));
        else m_ovf = 1'b1;
      end
      if (q.size() > 0) m_last = q[0];
    end
  end

  always @(negedge clkin) begin
    if (model_en) begin
      chk("model_valid", 16'(out_valid), 16'(q.size() != 0));
      chk("model_overflow", 16'(overflow), 16'(m_ovf));
      chk("model_head", {7'd0, out_data, out_sat}, {7'd0, m_last});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Raise ready with a new product, check the head after the capture edge, then drop ready.
  task automatic pulse_chk(input string nm, input int p, input bit s,
                           input logic [7:0] exp_d, input bit exp_s);
    mul_product = 14'(p); mul_sign = s; mul_ready = 1'b1;
    @(posedge clkin); @(negedge clkin);
    chk(nm, {6'd0, out_valid, out_sat, out_data}, {6'd0, 1'b1, exp_s, exp_d});
    @(posedge clkin); #1 mul_ready = 1'b0;
    step(1);
  endtask

  task automatic pulse(input int p);
    mul_product = 14'(p); mul_sign = 1'b0; mul_ready = 1'b1;
    step(1);
    mul_ready = 1'b0;
    step(1);
  endtask

  initial begin
    // Pin the model to hand-computed values
    chk("pin_090", 16'(expect_entry(1024, 1'b1)), 16'({8'h90, 1'b0}));
    chk("pin_sat", 16'(expect_entry(16129, 1'b1)), 16'({8'hFF, 1'b1}));
    chk("pin_nz",  16'(expect_entry(1, 1'b1)), 16'({8'h00, 1'b0}));

    mul_ready = 1'b1;
    step(2);
    @(negedge clkin);
    chk("reset_state", {4'd0, out_valid, out_sat, overflow, 1'b0, out_data},
        16'h0000);
    @(posedge clkin); #1 rst = 1'b0;
    model_en = 1'b1;
    step(3);
    @(negedge clkin);
    chk("ready_high_after_reset", 16'(out_valid), 16'd0);
    @(posedge clkin); #1 mul_ready = 1'b0;
    out_ready = 1'b1;
    step(1);

    pulse_chk("half_half_neg", 1024, 1'b1, 8'h90, 1'b0);
    pulse_chk("round_up", 1056, 1'b0, 8'h11, 1'b0);
    pulse_chk("round_down", 1055, 1'b0, 8'h10, 1'b0);
    pulse_chk("saturate", 16129, 1'b1, 8'hFF, 1'b1);
    pulse_chk("neg_zero", 1, 1'b1, 8'h00, 1'b0);
    pulse_chk("max_no_sat", 8159, 1'b0, 8'h7F, 1'b0);
    pulse_chk("round_into_sat", 8160, 1'b0, 8'h7F, 1'b1);

    // Fill the buffer with the consumer stalled
    out_ready = 1'b0;
    pulse(1024); pulse(2048); pulse(4096);
    @(negedge clkin);
    chk("ovf_set", {6'd0, overflow, out_valid, out_data}, {6'd0, 1'b1, 1'b1, 8'h10});
    @(posedge clkin); #1 out_ready = 1'b1;
    @(posedge clkin); @(negedge clkin);
    chk("drain_second", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 8'h20});
    @(posedge clkin); @(negedge clkin);
    chk("drain_empty", {7'd0, out_valid, out_data}, {7'd0, 1'b0, 8'h20});

    // Held ready produces exactly one entry
    #1 out_ready = 1'b0;
    mul_product = 14'd2048; mul_ready = 1'b1;
    step(10);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(1);
    @(negedge clkin);
    chk("held_ready_one_entry", {7'd0, out_valid, overflow}, {7'd0, 2'b01});

    // Reset mid-stream with ready high
    #1 rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clkin);
    chk("rst_clears", {7'd0, out_valid, overflow}, 16'd0);
    step(5);
    @(negedge clkin);
    chk("no_capture_after_rst", 16'(out_valid), 16'd0);
    #1 mul_ready = 1'b0;
    step(1);
    mul_ready = 1'b1;
    step(1);
    @(negedge clkin);
    chk("capture_after_toggle", {7'd0, out_valid, out_data}, {7'd0, 1'b1, 8'h20});

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      #1;
      mul_ready = ($urandom_range(0, 2) != 0) ? ~mul_ready : mul_ready;
      mul_sign  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: mul_product = 14'($urandom_range(8150, 8170));
        1: mul_product = 14'($urandom_range(0, 40));
        default: mul_product = 14'($urandom_range(0, 16383));
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clkin);
    end
    #1 rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
